// File: rtl/mult16u_shared_sched.sv
// Round-robin front end sharing one external combinational multiplier between NUM_REQ requesters.
// Two-stage stallable pipeline: S1 holds operands driving the multiplier, S2 holds the product for return.
module mult16u_shared_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_multiplicand,
  input  logic [NUM_REQ*WIDTH-1:0]   req_multiplier,
  input  logic [NUM_REQ-1:0]         req_mask,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_product,
  output logic [WIDTH-1:0]           mul_multiplicand,
  output logic [WIDTH-1:0]           mul_multiplier,
  input  logic [2*WIDTH-1:0]         mul_product,
  output logic                       busy,
  output logic [31:0]                issue_count
);

  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               r_v1;
  logic [TW-1:0]      r_tag1;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_v2;
  logic [TW-1:0]      r_tag2;
  logic [2*WIDTH-1:0] r_p;
  logic [TW-1:0]      r_ptr;
  logic [31:0]        r_issue_count;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_gnt_found;
  logic [TW-1:0]      w_gnt_idx;
  logic [TW-1:0]      w_cand;
  logic [TW-1:0]      w_ptr_next;
  logic               w_s2_adv;
  logic               w_s2_load_ok;
  logic               w_s1_load_ok;
  logic               w_s1_to_s2;
  logic               w_hs;
  logic [WIDTH-1:0]   w_a_sel;
  logic [WIDTH-1:0]   w_b_sel;

  assign w_elig = req_valid & req_mask;

  // Descending scan so the candidate closest to the pointer is written last and wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = TW'((int'(r_ptr) + k) % NUM_REQ);
      if (w_elig[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign w_s2_adv     = r_v2 & rsp_ready[r_tag2];
  assign w_s2_load_ok = ~r_v2 | w_s2_adv;
  assign w_s1_load_ok = ~r_v1 | w_s2_load_ok;
  assign w_s1_to_s2   = r_v1 & w_s2_load_ok;
  assign w_hs         = w_gnt_found & w_s1_load_ok & ~rst;

  assign w_ptr_next = (w_gnt_idx == TW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + TW'(1);
  assign w_a_sel    = req_multiplicand[w_gnt_idx*WIDTH +: WIDTH];
  assign w_b_sel    = req_multiplier[w_gnt_idx*WIDTH +: WIDTH];

  // Outputs are masked during reset so no handshake can complete against state being discarded.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign req_ready[gi] = w_hs & (w_gnt_idx == TW'(gi));
    assign rsp_valid[gi] = r_v2 & ~rst & (r_tag2 == TW'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1          <= 1'b0;
      r_tag1        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_v2          <= 1'b0;
      r_tag2        <= '0;
      r_p           <= '0;
      r_ptr         <= '0;
      r_issue_count <= '0;
    end else begin
      if (w_hs) begin
        r_v1          <= 1'b1;
        r_tag1        <= w_gnt_idx;
        r_a           <= w_a_sel;
        r_b           <= w_b_sel;
        r_ptr         <= w_ptr_next;
        r_issue_count <= r_issue_count + 32'd1;
      end else if (w_s1_to_s2) begin
        r_v1 <= 1'b0;
      end
      if (w_s1_to_s2) begin
        r_v2   <= 1'b1;
        r_tag2 <= r_tag1;
        r_p    <= mul_product;
      end else if (w_s2_adv) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign mul_multiplicand = r_a;
  assign mul_multiplier   = r_b;
  assign rsp_product      = r_p;
  assign busy             = r_v1 | r_v2;
  assign issue_count      = r_issue_count;

endmodule
